// File: rtl/weight_bram_sequencer_pkg.sv
// Shared ANN constants and sequencer state encoding, reused by the BRAM and MAC blocks.
`default_nettype none

package weight_bram_sequencer_pkg;

  localparam int ANN_DW    = 16;
  localparam int ANN_DEPTH = 28;
  localparam int ANN_AW    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READ  = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/weight_bram_sequencer_out_reg.sv
// One-entry valid/ready output register holding the weight presented to the MAC.
`default_nettype none

module weight_bram_sequencer_out_reg #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fill,
  input  logic [DW-1:0] fill_data,
  input  logic [AW-1:0] fill_idx,
  input  logic          fill_last,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_valid,
  output logic          out_last,
  output logic          slot_free
);

  // The slot can take a new word when empty or when the current one leaves this edge.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (fill) begin
      out_data  <= fill_data;
      out_idx   <= fill_idx;
      out_valid <= 1'b1;
      out_last  <= fill_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/weight_bram_sequencer.sv
// Owns one weight BRAM port: loads a weight set from a stream, or streams all weights to the MAC.
`default_nettype none

module weight_bram_sequencer
  import weight_bram_sequencer_pkg::*;
#(
  parameter int DEPTH = ANN_DEPTH,
  parameter int AW    = ANN_AW,
  parameter int DW    = ANN_DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          load_req,
  input  logic [DW-1:0] load_data,
  input  logic          load_valid,
  output logic          load_ready,
  output logic [DW-1:0] w_out,
  output logic [AW-1:0] w_idx,
  output logic          w_valid,
  input  logic          w_ready,
  output logic          w_last,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_di,
  output logic          bram_en,
  output logic          bram_we,
  input  logic [DW-1:0] bram_do
);

  localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_END  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  seq_state_t  state;
  seq_state_t  state_nxt;
  logic [AW:0] cnt;
  logic        pending;
  logic        slot_free;
  logic        fill;
  logic        load_beat;
  logic        issue_rd;

  // A read waits in BRAM_DO (EN stays low, so it holds) until the output slot frees up.
  assign fill = pending && slot_free;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (load_req) begin
          state_nxt = ST_LOAD;
        end else if (start) begin
          state_nxt = ST_READ;
        end
      end
      ST_LOAD: begin
        if (load_beat && cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issue_rd && cnt == CNT_LAST) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_valid && w_last && w_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == ST_LOAD);
    busy       = (state != ST_IDLE);
    load_beat  = (state == ST_LOAD) && load_valid;
    issue_rd   = (state == ST_READ) && (cnt < CNT_END) && slot_free;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      pending   <= 1'b0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_di   <= '0;
      done      <= 1'b0;
    end else begin
      bram_en <= load_beat || issue_rd;
      bram_we <= load_beat;
      done    <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
      pending <= issue_rd || (pending && !slot_free);
      if (state == ST_IDLE) begin
        cnt <= '0;
      end else if (load_beat || issue_rd) begin
        cnt <= cnt + (AW+1)'(1);
      end
      if (load_beat || issue_rd) begin
        bram_addr <= cnt[AW-1:0];
      end
      if (load_beat) begin
        bram_di <= load_data;
      end
    end
  end

  weight_bram_sequencer_out_reg #(
    .AW (AW),
    .DW (DW)
  ) u_out_reg (
    .clk       (clk),
    .rstn      (rstn),
    .fill      (fill),
    .fill_data (bram_do),
    .fill_idx  (bram_addr),
    .fill_last (bram_addr == IDX_LAST),
    .out_ready (w_ready),
    .out_data  (w_out),
    .out_idx   (w_idx),
    .out_valid (w_valid),
    .out_last  (w_last),
    .slot_free (slot_free)
  );

endmodule

`default_nettype wire

// File: tb/tb_weight_bram_sequencer.sv
// Bench for weight_bram_sequencer with a falling-edge BRAM model and an array-based reference.
`default_nettype none

module tb_weight_bram_sequencer;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          load_req = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_valid = 1'b0;
  logic          w_ready = 1'b0;
  logic          load_ready, w_valid, w_last, busy, done, bram_en, bram_we;
  logic [DW-1:0] w_out, bram_di;
  logic [DW-1:0] bram_do = '0;
  logic [AW-1:0] w_idx, bram_addr;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] = bram_di;
      else bram_do = mem[bram_addr];
    end
  end

  weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .load_req(load_req), .load_data(load_data),
    .load_valid(load_valid), .load_ready(load_ready), .w_out(w_out), .w_idx(w_idx),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_di(bram_di), .bram_en(bram_en), .bram_we(bram_we),
    .bram_do(bram_do)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({load_ready, w_valid, w_last, busy, done, bram_en, bram_we} !== 7'b0 ||
        w_out !== '0 || w_idx !== '0 || bram_addr !== '0 || bram_di !== '0) begin
      errors++;
      $display("FAIL %s: flags=%b w_out=%h w_idx=%0d addr=%0d di=%h, required all zero", name,
               {load_ready, w_valid, w_last, busy, done, bram_en, bram_we}, w_out, w_idx,
               bram_addr, bram_di);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rstn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready, 3: hold last word 5 cycles
  task automatic run_stream(input int mode, input int abort_idx);
    int  e, exp_idx, reads, first_valid, done_edge, hold;
    logic prev_stall, prev_acc_last;
    logic [DW-1:0] prev_out;
    logic [AW-1:0] prev_idx;
    bit  fin;
    e = 0; exp_idx = 0; reads = 0; first_valid = -1; done_edge = -1; hold = 0;
    prev_stall = 1'b0; prev_acc_last = 1'b0; prev_out = '0; prev_idx = '0; fin = 1'b0;
    w_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!fin) begin
      if (bram_en && !bram_we) reads++;
      if (w_valid && first_valid < 0) first_valid = e;
      if (w_valid) begin
        checks++;
        if (exp_idx >= DEPTH) begin
          errors++;
          $display("FAIL stream_extra: w_idx=%0d presented after all %0d weights", w_idx, DEPTH);
        end else if (w_idx !== exp_idx[AW-1:0] || w_out !== ref_mem[exp_idx] ||
                     w_last !== (exp_idx == DEPTH - 1)) begin
          errors++;
          $display("FAIL stream_word: idx=%0d out=%h last=%b, required idx=%0d out=%h last=%b",
                   w_idx, w_out, w_last, exp_idx, ref_mem[exp_idx], exp_idx == DEPTH - 1);
        end
      end
      if (prev_stall) begin
        checks++;
        if (w_valid !== 1'b1 || w_out !== prev_out || w_idx !== prev_idx || bram_en !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: valid=%b out=%h idx=%0d en=%b, required 1 %h %0d 0",
                   w_valid, w_out, w_idx, bram_en, prev_out, prev_idx);
        end
      end
      checks++;
      if (done !== prev_acc_last) begin
        errors++;
        $display("FAIL done_pulse: edge %0d done=%b, required %b", e, done, prev_acc_last);
      end
      if (done_edge >= 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_done: busy=%b, required 0", busy);
        end
        fin = 1'b1;
      end else if (done) begin
        done_edge = e;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: busy=%b, required 0", busy);
        end
      end
      if (abort_idx >= 0 && w_valid && w_idx == abort_idx[AW-1:0]) begin
        rstn = 1'b0;
        #1;
        check_all_zero("async_reset_midstream");
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      if (e > 600) begin
        errors++;
        $display("FAIL stream_timeout: delivered %0d of %0d", exp_idx, DEPTH);
        fin = 1'b1;
      end
      case (mode)
        1: w_ready = (e % 4 == 0) || (e % 4 == 3);
        2: w_ready = 1'($urandom_range(0, 1));
        3: begin
          if (w_valid && exp_idx == DEPTH - 1 && hold < 5) begin
            w_ready = 1'b0;
            hold++;
          end else begin
            w_ready = 1'b1;
          end
        end
        default: w_ready = 1'b1;
      endcase
      prev_stall    = w_valid && !w_ready;
      prev_acc_last = w_valid && w_ready && (exp_idx == DEPTH - 1);
      if (w_valid && w_ready) exp_idx++;
      prev_out = w_out;
      prev_idx = w_idx;
      if (!fin) begin
        step();
        e++;
      end
    end
    checks++;
    if (exp_idx != DEPTH || reads != DEPTH) begin
      errors++;
      $display("FAIL stream_count: delivered=%0d reads=%0d, required %0d %0d",
               exp_idx, reads, DEPTH, DEPTH);
    end
    if (mode == 0) begin
      checks++;
      if (first_valid != 2 || done_edge != DEPTH + 2) begin
        errors++;
        $display("FAIL stream_latency: first valid edge %0d done edge %0d, required 2 %0d",
                 first_valid, done_edge, DEPTH + 2);
      end
    end
    if (mode == 3) begin
      checks++;
      if (hold != 5) begin
        errors++;
        $display("FAIL flush_hold: held %0d cycles, required 5", hold);
      end
    end
  endtask

  task automatic run_load(input bit rnd, input bit with_start);
    int  i, cyc, bad;
    bit  gap, prev_gap, saw_read;
    i = 0; cyc = 0; bad = 0; prev_gap = 1'b0; saw_read = 1'b0;
    load_req = 1'b1;
    start = with_start;
    step();
    load_req = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_entry: busy=%b load_ready=%b, required 1 1", busy, load_ready);
    end
    while (i < DEPTH && cyc < 300) begin
      if (bram_en && !bram_we) saw_read = 1'b1;
      if (prev_gap) begin
        checks++;
        if (bram_en !== 1'b0) begin
          errors++;
          $display("FAIL load_gap_idle: bram_en=%b after gap, required 0", bram_en);
        end
      end
      gap = rnd ? ($urandom_range(0, 2) == 0) : (cyc % 3 == 2);
      load_valid = !gap;
      load_data  = rnd ? 16'($urandom) : 16'hA000 + 16'(i);
      start = (cyc == 5);
      if (load_valid && load_ready) begin
        ref_mem[i] = load_data;
        i++;
      end
      prev_gap = gap;
      step();
      cyc++;
    end
    load_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (i != DEPTH || done !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done: beats=%0d done=%b busy=%b ready=%b, required %0d 1 0 0",
               i, done, busy, load_ready, DEPTH);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || saw_read) begin
      errors++;
      $display("FAIL load_after: done=%b busy=%b read_seen=%b, required 0 0 0", done, busy, saw_read);
    end
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load_contents: %0d words differ, e.g. mem[0]=%h required %h",
               bad, mem[0], ref_mem[0]);
    end
  endtask

  task automatic test_stream_basic();   run_stream(0, -1); endtask
  task automatic test_backpressure();   run_stream(1, -1); endtask
  task automatic test_random_ready();   run_stream(2, -1); endtask
  task automatic test_load_then_stream();
    run_load(1'b0, 1'b0);
    run_stream(0, -1);
  endtask
  task automatic test_start_with_load();
    run_load(1'b1, 1'b1);
    run_stream(2, -1);
  endtask
  task automatic test_reset_midstream();
    run_stream(0, 10);
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b, required 0", busy);
    end
    run_stream(0, -1);
  endtask
  task automatic test_flush_hold();     run_stream(3, -1); endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem[k]     = 16'(k + 1);
      ref_mem[k] = 16'(k + 1);
    end
    @(negedge clk);
    test_reset();
    test_stream_basic();
    test_backpressure();
    test_random_ready();
    test_load_then_stream();
    test_start_with_load();
    test_reset_midstream();
    test_flush_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/weight_bram_sequencer.md
# weight_bram_sequencer

Controller that owns one per-neuron weight BRAM port (DEPTH×16-bit, 5-bit address, read registered on the falling clock edge). It has two jobs. It loads a fresh weight set from a streaming source. It also streams all weights out in address order to the neuron MAC, with a valid/ready handshake. Between the two jobs it arbitrates the single BRAM port, so the MAC never sees a write in flight. It sits between the layer controller and each Weight_x_y_z BRAM instance.

## Interface
- DEPTH, 28, number of weights (valid addresses 0..DEPTH-1)
- AW, 5, BRAM address width; requires DEPTH ≤ 2^AW
- DW, 16, weight width
- CLK  in  1  clock; all logic on rising edge (BRAM reads on falling edge)
- RSTN  in  1  reset, asynchronous, active-low
- START  in  1  pulse: stream all weights to MAC
- LOAD_REQ  in  1  pulse: overwrite all DEPTH weights from load stream
- LOAD_DATA  in  DW  load word
- LOAD_VALID  in  1  load word valid
- LOAD_READY  out  1  load word accepted when LOAD_VALID & LOAD_READY
- W_OUT  out  DW  weight to MAC
- W_IDX  out  AW  address of W_OUT
- W_VALID  out  1  W_OUT/W_IDX valid
- W_READY  in  1  MAC accepts when W_VALID & W_READY
- W_LAST  out  1  with W_VALID: W_IDX == DEPTH-1
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-cycle pulse at end of stream or load
- BRAM_ADDR  out  AW, BRAM_DI  out  DW, BRAM_EN  out  1, BRAM_WE  out  1, BRAM_DO  in  DW  BRAM port

## Operation
- States: IDLE, LOAD, READ, FLUSH.
- IDLE
  - LOAD_REQ → LOAD, counter=0.
  - Else START → READ, counter=0.
  - LOAD_REQ wins if both are high in the same cycle.
  - START/LOAD_REQ are ignored outside IDLE; no queuing.
- LOAD
  - LOAD_READY=1.
  - Each accepted beat drives BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=counter, BRAM_DI=LOAD_DATA, then counter+1.
  - Beat with counter==DEPTH-1 → IDLE, DONE pulse next cycle.
- READ
  - Issue condition: counter<DEPTH & (!W_VALID | W_READY).
  - On issue: BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=counter, counter+1.
  - Next rising edge captures BRAM_DO into W_OUT and the issued address into W_IDX, and sets W_VALID.
  - If not issuing and W_READY is high, clear W_VALID.
  - Issue of address DEPTH-1 → FLUSH.
- FLUSH
  - No issues.
  - When the last word (W_LAST) is accepted → IDLE, DONE pulse next cycle.
- BRAM_EN/BRAM_WE/BRAM_ADDR/BRAM_DI are registered outputs, set up before the falling edge. BRAM_EN=0 whenever no access is issued, so BRAM_DO holds.
- Counter is AW+1 bits wide; it never wraps past DEPTH.

## Timing
- Reset values:
  - All outputs 0.
  - state=IDLE, counter=0.
- READ latency: START high at edge 0 → first ADDR issue at edge 1 → W_VALID=1, W_IDX=0 at edge 2.
- Throughput with W_READY held high: one weight per cycle. The full stream takes DEPTH+2 cycles from START to DONE.
- Backpressure:
  - W_READY=0 with W_VALID=1 holds W_OUT/W_IDX/W_VALID stable.
  - No BRAM access is issued while stalled.
- LOAD throughput is one word per cycle while LOAD_VALID=1. LOAD_VALID gaps insert idle BRAM cycles (EN=0).
- RSTN deasserted mid-stream or mid-load: immediate return to IDLE, outputs zero. Partially written BRAM contents are left as written.
- DONE is exactly one cycle; BUSY falls in the same cycle DONE rises.

## Structure
- Shared ANN package holds:
  - state encoding (2-bit enum IDLE/LOAD/READ/FLUSH)
  - DW=16 and default DEPTH/AW constants, reused by BRAM and MAC blocks
- Optional sub-module `weight_out_reg`: one-entry output register with valid/ready. Everything else lives in one module.
- The BRAM itself is external; the bench instantiates a behavioural model that also reads on the falling edge.

## Test plan
- Reset, then START, W_READY=1, BRAM preloaded with w[i]=i+1 → W_VALID from edge 2. W_IDX 0..27 consecutive with W_OUT 1..28. W_LAST at idx 27. DONE at edge 30.
- START, W_READY toggling 1,0,0,1 (repeat) → every weight delivered exactly once, in order. W_OUT stable during stalls. BRAM_EN=0 while stalled.
- LOAD_REQ, then 28 beats 0xA000+i with LOAD_VALID gaps every 3rd cycle → BRAM holds 0xA000..0xA01B. A subsequent START streams them back.
- START and LOAD_REQ in the same cycle → LOAD entered, no read issued. START pulsed mid-LOAD is ignored.
- RSTN low at W_IDX=10 → all outputs 0 asynchronously, state IDLE. A new START streams from index 0.
- W_READY=0 on the last word in FLUSH for 5 cycles → DONE only after acceptance. No extra BRAM reads.
